// File: rtl/run_detect_sched.sv
// rtl/run_detect_sched.sv - word scheduler around a serial run-of-ones detector
//
// Accepts a WIDTH-bit word on in_valid/in_ready, scans it MSB-first one bit
// per cycle through a run-of-ones detector, then presents the per-word
// detection count on out_valid/out_ready.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   word handshake (ready only in IDLE)
//   in_data          word to scan, bit WIDTH-1 first
//   carry            at accept: 1 keeps detector run state, 0 clears it
//   out_valid/ready  count handshake (valid only in REPORT)
//   out_count        saturating detection count of the last word
//   ser_en, ser_bit  bit being scanned this cycle
//   hit              detection pulse, one cycle after the completing bit
module run_detect_sched #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             ser_en,
    output logic             ser_bit,
    output logic             hit
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [3:0]       RUN_TOP = 4'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic [3:0]       run;
    logic [CNT_W-1:0] count;
    logic             hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
            run   <= '0;
            count <= '0;
            hit_q <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= in_data;
                        idx   <= IDX_W'(WIDTH - 1);
                        count <= '0;
                        // Run state survives across words only when the
                        // producer asks for a continuous bit stream.
                        if (!carry) begin
                            run <= '0;
                        end
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    if (!sreg[WIDTH-1]) begin
                        run <= '0;
                    end else if (run == RUN_TOP) begin
                        // A detection restarts the run at one, so overlapping
                        // runs count every RUN_LEN-1 further ones.
                        run   <= 4'd1;
                        hit_q <= 1'b1;
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        run <= run + 4'd1;
                    end
                    if (idx == '0) begin
                        state <= REPORT;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is forced low during reset so nothing is accepted on a reset edge.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == REPORT);
    assign out_count = count;
    assign ser_en    = (state == SHIFT);
    assign ser_bit   = ser_en & sreg[WIDTH-1];
    assign hit       = hit_q;

endmodule

// File: tb/tb_run_detect_sched.sv
// tb/tb_run_detect_sched.sv - self-checking bench for run_detect_sched
module tb_run_detect_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, carry, out_valid, out_ready;
    logic [7:0] in_data;
    logic [3:0] out_count;
    logic       ser_en, ser_bit, hit;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] in_data2;
    logic [1:0]  out_count2;
    logic        ser_en2, ser_bit2, hit2;

    run_detect_sched #(.WIDTH(8), .RUN_LEN(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .carry(carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .ser_en(ser_en), .ser_bit(ser_bit), .hit(hit)
    );

    run_detect_sched #(.WIDTH(16), .RUN_LEN(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .carry(1'b0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_count(out_count2),
        .ser_en(ser_en2), .ser_bit(ser_bit2), .hit(hit2)
    );

    int passed = 0;
    int total  = 0;

    logic [3:0] sb[$];
    logic [1:0] sb2[$];

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic [3:0] cnt;
        logic [8:0] hits;   // bit k-1 = hit high in cycle T+k after accept
        int         stall;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int guard;
        logic [7:0] seq;
        logic [8:0] hits;
        logic en_ok;
        logic [3:0] stable;
        logic [3:0] exp;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = v.data;
        carry    = v.carry;
        @(posedge clk);
        sb.push_back(v.cnt);
        #1;
        in_valid = 1'b0;
        carry    = 1'b0;
        seq = '0; hits = '0; en_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            en_ok = en_ok & ser_en;
            seq   = {seq[6:0], ser_bit};
            hits[k-1] = hit;
        end
        @(negedge clk);
        hits[8] = hit;
        check({tag, " ser_en"}, {en_ok, ser_en}, 2'b10);
        check({tag, " ser_bit seq"}, seq, v.data);
        check({tag, " hit pattern"}, hits, v.hits);
        check({tag, " out_valid"}, {out_valid, in_ready}, 2'b10);
        stable = out_count;
        if (v.stall > 0) begin
            in_valid = 1'b1;
            in_data  = ~v.data;
        end
        for (int s = 0; s < v.stall; s++) begin
            check({tag, " stall"}, {out_valid, in_ready, out_count}, {1'b1, 1'b0, stable});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 1, 0);
            exp = '0;
        end else begin
            exp = sb.pop_front();
            check({tag, " out_count"}, {out_valid, out_count}, {1'b1, exp});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " after handshake"}, {out_valid, in_ready, out_count}, {1'b0, 1'b1, exp});
    endtask

    task automatic run_vec2(input logic [15:0] data, input logic [1:0] cnt, input int exp_hits);
        int g;
        int nh;
        g = 0;
        @(negedge clk);
        while (!in_ready2 && g < 50) begin
            @(negedge clk);
            g++;
        end
        in_valid2 = 1'b1;
        in_data2  = data;
        @(posedge clk);
        sb2.push_back(cnt);
        #1;
        in_valid2 = 1'b0;
        g = 0; nh = 0;
        do begin
            @(negedge clk);
            nh += int'(hit2);
            g++;
        end while (!out_valid2 && g < 40);
        check("w16 out_valid", out_valid2, 1);
        check("w16 hit count", nh, exp_hits);
        out_ready2 = 1'b1;
        check("w16 out_count", out_count2, sb2.pop_front());
        @(posedge clk);
        #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 1'b0, 4'd3, 9'h0A8, 0};
        vecs[1] = '{8'hE7, 1'b0, 4'd2, 9'h108, 5};
        vecs[2] = '{8'h03, 1'b0, 4'd0, 9'h000, 0};
        vecs[3] = '{8'h80, 1'b1, 4'd1, 9'h002, 0};
        vecs[4] = '{8'h03, 1'b0, 4'd0, 9'h000, 0};
        vecs[5] = '{8'h80, 1'b0, 4'd0, 9'h000, 0};
        vecs[6] = '{8'h7F, 1'b0, 4'd3, 9'h150, 0};
        vecs[7] = '{8'hC0, 1'b1, 4'd1, 9'h004, 0};
        vecs[8] = '{8'hB6, 1'b0, 4'd0, 9'h000, 0};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; carry = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", {in_ready, in_ready2}, 2'b00);
        check("reset outputs", {out_valid, hit, ser_en, ser_bit, out_count}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post reset in_ready", {in_ready, out_valid, in_ready2}, 3'b101);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of scanning 8'hFF
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; carry = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid scanning", ser_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset outputs", {out_valid, hit, ser_en, in_ready}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("mid reset idle", {in_ready, out_valid, hit, ser_en}, 4'b1000);
        run_vec('{8'h07, 1'b1, 4'd1, 9'h100, 0}, "post-reset carry");

        run_vec2(16'hFFFF, 2'd3, 15);
        run_vec2(16'h0000, 2'd0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/run_detect_sched.md
# run_detect_sched

Word-level scheduler wrapped around the team's serial run-of-ones detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first through an embedded run detector, one bit per cycle. It counts detections per word and presents the count on a second valid/ready handshake. It sits between a parallel producer and any consumer of per-word detection statistics, and owns the sequencing that the bare bit-serial detector lacks.

## Interface
- WIDTH, 8, input word width (≥2)
- RUN_LEN, 3, consecutive ones needed for a detection (2..15)
- CNT_W, 4, width of per-word detection count (saturating)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word (high only in IDLE)
- in_data  in  WIDTH  word to scan, bit WIDTH-1 scanned first
- carry  in  1  sampled at accept; 1 = keep detector run state from previous word, 0 = clear it
- out_valid  out  1  detection count available
- out_ready  in  1  consumer takes count
- out_count  out  CNT_W  detections in last word
- ser_en  out  1  a bit is being scanned this cycle
- ser_bit  out  1  bit being scanned this cycle
- hit  out  1  one-cycle detection pulse

## Operation
- States: IDLE, SHIFT, REPORT.
- IDLE: in_ready=1. On in_valid=1, accept: load shift register with in_data, bit index=WIDTH-1, count=0, run=0 if carry=0 else run kept; next state SHIFT.
- SHIFT: ser_en=1, ser_bit=current bit. Run rule per bit, applied at the edge:
  - bit=0: run=0.
  - bit=1 and run==RUN_LEN-1: detection; run=1; count=count+1 (saturates at 2^CNT_W-1).
  - bit=1 otherwise: run=run+1.
- After bit 0 is processed, next state REPORT.
- With RUN_LEN=3, a detection restarts the run at 1. Eleven ones give detections on bits 3, 5, 7, 9, 11.
- REPORT: out_valid=1, out_count holds the final count, stable until handshake. On out_ready=1, next state IDLE. in_ready=0 throughout, so a new word is never accepted while a count is pending.
- Run state persists through REPORT and IDLE. It is cleared only by rst or by an accept with carry=0.
- in_valid is ignored outside IDLE. out_ready is ignored outside REPORT. carry is ignored except at accept.

## Timing
- Reset (edge with rst=1) values: state=IDLE, run=0, count=0, out_count=0, out_valid=0, hit=0, ser_en=0, ser_bit=0.
- in_ready is low in any cycle with rst=1. It is high from the first cycle after reset.
- rst overrides everything, in any state including mid-SHIFT or REPORT. The word in flight is discarded with no out_valid.
- Accept at edge ending cycle T → ser_en high in cycles T+1..T+WIDTH → out_valid high from cycle T+WIDTH+1.
- hit is registered: it is high in the cycle after the completing bit was scanned. A detection on the last bit pulses hit in the first REPORT cycle.
- Count handshake at edge ending cycle R → IDLE in R+1 (in_ready=1), out_valid=0. out_count retains its value until the next accept.
- Best-case throughput: one word per WIDTH+2 cycles, with in_valid and out_ready held high.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- WIDTH=8, RUN_LEN=3, carry=0, in_data=8'hFF → hit pulses in cycles T+4, T+6, T+8 → out_valid at T+9, out_count=3.
- in_data=8'hE7 (11100111), carry=0 → hits after bits 3 and 8 → out_count=2. ser_bit sequence is 1,1,1,0,0,1,1,1.
- Carry test: word 8'h03, then word 8'h80 with carry=1 → second count=1, hit in cycle after first scanned bit. Repeat with carry=0 → second count=0.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT while in_valid=1 → out_valid stays 1, out_count stable, in_ready=0, no new accept. Raise out_ready → IDLE next cycle, then accept.
- Reset mid-operation: assert rst after 4 scanned bits of 8'hFF → next cycle IDLE, out_valid=0, hit=0, ser_en=0, run cleared. Then 8'h07 with carry=1 → out_count=1.
- Saturation/zero: CNT_W=2, WIDTH=16, RUN_LEN=2, in_data=16'hFFFF → out_count=3 (saturated). in_data=16'h0000 → out_count=0, hit never asserted.
